// File: rtl/game_pkg.sv
// Shared types and constants for the game controller and its score counter.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        DYING     = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    typedef logic [11:0] bcd3_t;

    localparam bcd3_t SCORE_MAX = 12'h999;

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter with synchronous clear and saturating increment.
// Latency: count updates on the clock after inc/clr.
// Backpressure: none; inc at SCORE_MAX is dropped.
module bcd_counter3
    import game_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  clr,
    output bcd3_t count
);

    bcd3_t count_inc;

    always_comb begin
        count_inc = count;
        if (count != SCORE_MAX) begin
            if (count[3:0] != 4'd9) begin
                count_inc[3:0] = count[3:0] + 4'd1;
            end else begin
                count_inc[3:0] = 4'd0;
                if (count[7:4] != 4'd9) begin
                    count_inc[7:4] = count[7:4] + 4'd1;
                end else begin
                    count_inc[7:4]  = 4'd0;
                    count_inc[11:8] = count[11:8] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game sequencing FSM: start/flap handling, collision filter, death timer, scores.
// Latency: all outputs registered, one cycle after the triggering input.
// Backpressure: none; inputs are sampled every cycle, flap edges outside IDLE/PLAYING/GAME_OVER are dropped.
module game_controller
    import game_pkg::*;
#(
    parameter int DEATH_FRAMES   = 60,
    parameter int COLLIDE_FILTER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        flap_btn,
    input  logic        collision_in,
    input  logic        pipe_passed,
    output logic [1:0]  state_out,
    output logic        world_reset,
    output logic        flap_pulse,
    output logic        motion_en,
    output logic [11:0] score,
    output logic [11:0] high_score
);

    localparam logic [7:0] DEATH_LAST   = 8'(DEATH_FRAMES - 1);
    localparam logic [2:0] COLLIDE_LAST = 3'(COLLIDE_FILTER - 1);

    game_state_t state_q, state_nxt;
    logic        flap_q;
    logic        flap_edge;
    logic [2:0]  coll_cnt, coll_nxt;
    logic [7:0]  death_cnt, death_nxt;
    logic        wr_nxt, fp_nxt;
    logic        score_inc;

    assign flap_edge = flap_btn & ~flap_q;

    always_comb begin
        state_nxt = state_q;
        coll_nxt  = coll_cnt;
        death_nxt = death_cnt;
        wr_nxt    = 1'b0;
        fp_nxt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flap_edge) begin
                    state_nxt = PLAYING;
                    wr_nxt    = 1'b1;
                    fp_nxt    = 1'b1;
                    coll_nxt  = '0;
                    death_nxt = '0;
                end
            end
            PLAYING: begin
                fp_nxt = flap_edge;
                if (frame_tick) begin
                    if (!collision_in) begin
                        coll_nxt = '0;
                    end else if (coll_cnt == COLLIDE_LAST) begin
                        // Filter satisfied: the counter would reach the threshold on this edge.
                        state_nxt = DYING;
                        coll_nxt  = '0;
                        death_nxt = '0;
                    end else begin
                        coll_nxt = coll_cnt + 3'd1;
                    end
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (death_cnt == DEATH_LAST) begin
                        state_nxt = GAME_OVER;
                        death_nxt = '0;
                    end else begin
                        death_nxt = death_cnt + 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (flap_edge) begin
                    state_nxt = IDLE;
                    wr_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flap_q      <= 1'b0;
            coll_cnt    <= '0;
            death_cnt   <= '0;
            world_reset <= 1'b0;
            flap_pulse  <= 1'b0;
            motion_en   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            flap_q      <= flap_btn;
            coll_cnt    <= coll_nxt;
            death_cnt   <= death_nxt;
            world_reset <= wr_nxt;
            flap_pulse  <= fp_nxt;
            motion_en   <= (state_nxt == PLAYING);
        end
    end

    // Packed BCD orders digits by weight, so a plain compare is a magnitude compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            high_score <= '0;
        end else if (state_q == GAME_OVER && score > high_score) begin
            high_score <= score;
        end
    end

    assign score_inc = pipe_passed && (state_q == PLAYING);
    assign state_out = state_q;

    bcd_counter3 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (score_inc),
        .clr   (wr_nxt),
        .count (score)
    );

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, frame_tick, flap_btn, collision_in, pipe_passed;
    logic [1:0]  state_out;
    logic        world_reset, flap_pulse, motion_en;
    logic [11:0] score, high_score;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_controller #(.DEATH_FRAMES(60), .COLLIDE_FILTER(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .flap_btn     (flap_btn),
        .collision_in (collision_in),
        .pipe_passed  (pipe_passed),
        .state_out    (state_out),
        .world_reset  (world_reset),
        .flap_pulse   (flap_pulse),
        .motion_en    (motion_en),
        .score        (score),
        .high_score   (high_score)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; flap_btn = 1'b0;
        collision_in = 1'b0; pipe_passed = 1'b0;
        step; step;
        chk("rst_state", 12'(state_out), 12'd0);
        chk("rst_score", score, 12'h000);
        chk("rst_high", high_score, 12'h000);
        chk("rst_wr", 12'(world_reset), 12'd0);
        chk("rst_fp", 12'(flap_pulse), 12'd0);
        chk("rst_me", 12'(motion_en), 12'd0);

        // Pipes in IDLE must not score
        rst_n = 1'b1; pipe_passed = 1'b1; step; pipe_passed = 1'b0;
        chk("idle_pipe", score, 12'h000);

        // Game 1: start
        flap_btn = 1'b1; step;
        chk("g1_start_state", 12'(state_out), 12'd1);
        chk("g1_start_wr", 12'(world_reset), 12'd1);
        chk("g1_start_fp", 12'(flap_pulse), 12'd1);
        chk("g1_start_me", 12'(motion_en), 12'd1);
        step;
        chk("g1_wr_one", 12'(world_reset), 12'd0);
        chk("g1_fp_one", 12'(flap_pulse), 12'd0);
        chk("g1_held_state", 12'(state_out), 12'd1);
        flap_btn = 1'b0; step;

        pipe_passed = 1'b1; repeat (3) step; pipe_passed = 1'b0;
        chk("g1_score3", score, 12'h003);

        // Single colliding tick, then a clear tick: keep playing
        collision_in = 1'b1; frame_tick = 1'b1; step; frame_tick = 1'b0; step;
        collision_in = 1'b0; frame_tick = 1'b1; step; frame_tick = 1'b0; step;
        chk("g1_single_coll", 12'(state_out), 12'd1);

        // Two consecutive colliding ticks: DYING right after the second
        collision_in = 1'b1; frame_tick = 1'b1; step; frame_tick = 1'b0; step;
        chk("g1_first_of_two", 12'(state_out), 12'd1);
        frame_tick = 1'b1; step; frame_tick = 1'b0; collision_in = 1'b0;
        chk("g1_dying", 12'(state_out), 12'd2);
        chk("g1_dying_me", 12'(motion_en), 12'd0);

        // 59 ticks with flap edges and pipes: still DYING, no flap pulse, no scoring
        for (int i = 1; i <= 59; i++) begin
            frame_tick = 1'b1; flap_btn = ~flap_btn; pipe_passed = 1'b1;
            step;
            frame_tick = 1'b0; pipe_passed = 1'b0;
            chk("g1_dying_fp", 12'(flap_pulse), 12'd0);
            step;
            chk("g1_dying_hold", 12'(state_out), 12'd2);
        end
        flap_btn = 1'b0;
        chk("g1_dying_score", score, 12'h003);
        frame_tick = 1'b1; step; frame_tick = 1'b0;
        chk("g1_gameover", 12'(state_out), 12'd3);
        chk("g1_high_pre", high_score, 12'h000);
        step;
        chk("g1_high_load", high_score, 12'h003);

        flap_btn = 1'b1; step;
        chk("g1_idle_state", 12'(state_out), 12'd0);
        chk("g1_idle_wr", 12'(world_reset), 12'd1);
        chk("g1_idle_fp", 12'(flap_pulse), 12'd0);
        chk("g1_idle_score", score, 12'h000);
        chk("g1_idle_high", high_score, 12'h003);
        flap_btn = 1'b0; step;
        chk("g1_idle_wr_one", 12'(world_reset), 12'd0);

        // Game 2: score 7 beats high score 3
        flap_btn = 1'b1; step;
        chk("g2_start", 12'(state_out), 12'd1);
        flap_btn = 1'b0; step;
        pipe_passed = 1'b1; repeat (5) step;
        chk("g2_score5", score, 12'h005);
        repeat (2) step; pipe_passed = 1'b0;
        chk("g2_score7", score, 12'h007);

        // Flap edge coincident with a colliding tick: both take effect
        flap_btn = 1'b1; frame_tick = 1'b1; collision_in = 1'b1; step;
        chk("g2_coinc_fp", 12'(flap_pulse), 12'd1);
        chk("g2_coinc_state", 12'(state_out), 12'd1);
        flap_btn = 1'b0; frame_tick = 1'b0; step;
        chk("g2_coinc_fp_one", 12'(flap_pulse), 12'd0);
        frame_tick = 1'b1; step; frame_tick = 1'b0; collision_in = 1'b0;
        chk("g2_dying", 12'(state_out), 12'd2);

        repeat (59) begin
            frame_tick = 1'b1; step; frame_tick = 1'b0; step;
        end
        chk("g2_tick59", 12'(state_out), 12'd2);
        frame_tick = 1'b1; step; frame_tick = 1'b0;
        chk("g2_gameover", 12'(state_out), 12'd3);
        chk("g2_high_pre", high_score, 12'h003);
        step;
        chk("g2_high_load", high_score, 12'h007);
        flap_btn = 1'b1; step; flap_btn = 1'b0;
        chk("g2_idle_score", score, 12'h000);
        chk("g2_idle_high", high_score, 12'h007);
        step;

        // Game 3: saturation and reset mid-play
        flap_btn = 1'b1; step; flap_btn = 1'b0; step;
        pipe_passed = 1'b1; repeat (999) step;
        chk("g3_score999", score, 12'h999);
        step; pipe_passed = 1'b0;
        chk("g3_saturate", score, 12'h999);

        flap_btn = 1'b1; step;
        chk("g3_play_fp", 12'(flap_pulse), 12'd1);
        step;
        chk("g3_play_fp_one", 12'(flap_pulse), 12'd0);
        flap_btn = 1'b0; step;

        rst_n = 1'b0; step;
        chk("g3_rst_state", 12'(state_out), 12'd0);
        chk("g3_rst_score", score, 12'h000);
        chk("g3_rst_high", high_score, 12'h000);
        chk("g3_rst_me", 12'(motion_en), 12'd0);
        chk("g3_rst_wr", 12'(world_reset), 12'd0);
        chk("g3_rst_fp", 12'(flap_pulse), 12'd0);
        rst_n = 1'b1; step;
        chk("g3_post_rst", 12'(state_out), 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
